// File: rtl/flash_boot_copier_pkg.sv
// Shared constants for the flash boot copier and its ack timer: reset level,
// bus widths, state encoding and the word-address helper.
package flash_boot_copier_pkg;

   localparam logic RstEnable = 1'b1;

   typedef logic [15:0] FlashBootIdxBus;
   typedef logic [7:0]  FlashBootToBus;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_RD_GAP = 3'd2,
      S_WR     = 3'd3,
      S_WR_GAP = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } fbc_state_e;

   localparam logic [3:0] SelAll  = 4'hF;
   localparam logic [3:0] SelNone = 4'h0;

   // Byte address of word idx relative to base; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input FlashBootIdxBus idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/flash_boot_copier_wb_ack_timer.sv
// 8-bit saturating ack-timeout counter; held at zero by clr_i, counts while en_i.
// expired_o is set once the count has reached LIMIT.
module flash_boot_copier_wb_ack_timer
   import flash_boot_copier_pkg::*;
#(
   parameter FlashBootToBus LIMIT = 8'd255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   FlashBootToBus cnt_q;

   // Cycle counter, saturating at all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i == RstEnable) begin
         cnt_q <= 8'd0;
      end else if (clr_i) begin
         cnt_q <= 8'd0;
      end else if (en_i && (cnt_q != 8'hFF)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/flash_boot_copier.sv
// Wishbone master copying WORDS words from flash (SRC_BASE) to RAM (DST_BASE), holding the CPU
// in reset until done. Optional running checksum: FLASH_BOOT_CHECKSUM_EN.
module flash_boot_copier
   import flash_boot_copier_pkg::*;
#(
   parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
   parameter logic [31:0] DST_BASE   = 32'h0000_0000,
   parameter int          WORDS      = 1024,
   parameter int          TIMEOUT    = 255,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   input  logic        wbm_ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        cpu_rst_o,
   output logic [31:0] checksum_o
);

   localparam FlashBootIdxBus LastIdx = FlashBootIdxBus'(WORDS - 1);

   fbc_state_e     state_q;
   FlashBootIdxBus idx_q;
   logic [31:0]    adr_q;
   logic [31:0]    dat_q;
   logic [3:0]     sel_q;
   logic           cyc_q;
   logic           we_q;
   logic           busy_q;
   logic           done_q;
   logic           err_q;
   logic           cpu_rst_q;
   logic           first_q;

   logic ack_s;
   logic on_bus_s;
   logic idle_s;
   logic go_s;
   logic expired_s;

   // Acks are only meaningful while our own cycle is open.
   assign ack_s    = wbm_ack_i & cyc_q;
   assign on_bus_s = (state_q == S_RD) || (state_q == S_WR);
   assign idle_s   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
   assign go_s     = idle_s && (start_i || (AUTO_START && first_q));

   flash_boot_copier_wb_ack_timer #(
      .LIMIT(FlashBootToBus'(TIMEOUT))
   ) u_timer (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .clr_i    (~on_bus_s),
      .en_i     (on_bus_s),
      .expired_o(expired_s)
   );

   // Copy sequencer with registered bus and status outputs.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i == RstEnable) begin
         state_q   <= S_IDLE;
         idx_q     <= 16'd0;
         adr_q     <= 32'h0;
         dat_q     <= 32'h0;
         sel_q     <= SelNone;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cpu_rst_q <= 1'b1;
         first_q   <= 1'b1;
      end else begin
         first_q <= 1'b0;
         case (state_q)
            S_RD, S_WR: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  sel_q <= SelAll;
                  we_q  <= (state_q == S_WR);
                  adr_q <= (state_q == S_WR) ? word_addr(DST_BASE, idx_q)
                                             : word_addr(SRC_BASE, idx_q);
               end else if (ack_s) begin
                  cyc_q <= 1'b0;
                  sel_q <= SelNone;
                  we_q  <= 1'b0;
                  if (state_q == S_RD) begin
                     dat_q   <= wbm_dat_i;
                     state_q <= S_RD_GAP;
                  end else if (idx_q == LastIdx) begin
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     cpu_rst_q <= 1'b0;
                     busy_q    <= 1'b0;
                  end else begin
                     idx_q   <= idx_q + 16'd1;
                     state_q <= S_WR_GAP;
                  end
               end else if (expired_s) begin
                  cyc_q   <= 1'b0;
                  sel_q   <= SelNone;
                  we_q    <= 1'b0;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_ERR;
               end
            end
            S_RD_GAP: state_q <= S_WR;
            S_WR_GAP: state_q <= S_RD;
            S_IDLE, S_DONE, S_ERR: begin
               if (go_s) begin
                  state_q   <= S_RD;
                  idx_q     <= 16'd0;
                  done_q    <= 1'b0;
                  err_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  cpu_rst_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef FLASH_BOOT_CHECKSUM_EN
   logic [31:0] checksum_q;
   logic        wr_ack_s;

   assign wr_ack_s = (state_q == S_WR) & ack_s;

   // Running modulo-2^32 sum of every word acknowledged by the RAM.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i == RstEnable) begin
         checksum_q <= 32'h0;
      end else if (go_s) begin
         checksum_q <= 32'h0;
      end else if (wr_ack_s) begin
         checksum_q <= checksum_q + dat_q;
      end
   end

   assign checksum_o = checksum_q;
`else
   assign checksum_o = 32'h0;
`endif

   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;
   assign wbm_we_o  = we_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_cyc_o = cyc_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign cpu_rst_o = cpu_rst_q;

endmodule

// File: tb/tb_flash_boot_copier.sv
// Scoreboard bench for flash_boot_copier: flash/RAM slave models, expected accesses queued at
// each start and popped by a bus monitor on every acknowledged access.
module tb_flash_boot_copier;

   localparam logic [31:0] SRC = 32'h1000_0000;
   localparam logic [31:0] DST = 32'hFFFF_FFF8;
   localparam int NW = 4;
   localparam int TO = 16;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      bit          last;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [31:0] adr_o, dat_o, dat_i, checksum;
   logic [3:0]  sel_o;
   logic we_o, stb_o, cyc_o, ack_i, busy, done, err, cpu_rst;

   int checks = 0;
   int errors = 0;
   logic [31:0] flash [NW];
   logic [31:0] ram [logic [31:0]];
   wr_t         exp_q[$];
   logic [31:0] rd_q[$];
   int rd_lat = 14;
   int wr_lat = 1;
   int stall_word = -1;
   int stall_cnt = 0;
   int acc_cnt = 0;
   bit after_ack = 1'b0;
   bit done_next = 1'b0;
   bit prev_stall = 1'b0;

   flash_boot_copier #(
      .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(NW), .TIMEOUT(TO), .AUTO_START(1'b1)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
      .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_sel_o(sel_o),
      .wbm_we_o(we_o), .wbm_stb_o(stb_o), .wbm_cyc_o(cyc_o), .wbm_ack_i(ack_i),
      .busy_o(busy), .done_o(done), .err_o(err), .cpu_rst_o(cpu_rst), .checksum_o(checksum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Flash/RAM slave: flash acks on the rd_lat-th cycle of cyc (never for stall_word), RAM on wr_lat-th.
   always @(negedge clk) begin
      int w;
      if (rst) begin
         ack_i = 1'b0; dat_i = 32'h0; acc_cnt = 0;
      end else if (cyc_o) begin
         acc_cnt++;
         w = int'((adr_o - (we_o ? DST : SRC)) >> 2);
         if (we_o) begin
            ack_i = (acc_cnt == wr_lat);
         end else begin
            dat_i = (w >= 0 && w < NW) ? flash[w] : 32'hDEAD_BEEF;
            ack_i = (acc_cnt == rd_lat) && (w != stall_word);
         end
      end else begin
         acc_cnt = 0;
         ack_i = ($urandom_range(3) == 0);
         dat_i = $urandom;
      end
   end

   // Monitor: protocol rules every cycle, scoreboard pop on every acknowledged access.
   always @(negedge clk) begin
      wr_t e;
      logic [31:0] ra;
      bit hit;
      #2;
      if (rst) begin
         after_ack = 1'b0; done_next = 1'b0; prev_stall = 1'b0;
      end else begin
         if (after_ack) chk1("cyc_gap_after_ack", cyc_o, 1'b0);
         after_ack = 1'b0;
         if (done_next) begin
            chk1("done_after_last_ack", done, 1'b1);
            chk1("cpu_rst_after_last_ack", cpu_rst, 1'b0);
         end
         done_next = 1'b0;
         chk1("stb_equals_cyc", stb_o, cyc_o);
         chk("sel_phase", {28'h0, sel_o}, cyc_o ? 32'hF : 32'h0);
         hit = cyc_o && !we_o && (stall_word >= 0) && (adr_o == SRC + 32'(stall_word) * 32'd4);
         if (hit) stall_cnt++;
         if (prev_stall && !cyc_o) chk1("err_with_release", err, 1'b1);
         prev_stall = hit;
         if (cyc_o && ack_i) begin
            after_ack = 1'b1;
            if (we_o) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write actual=%h required=none", adr_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_adr", adr_o, e.adr);
                  chk("wr_dat", dat_o, e.dat);
                  ram[adr_o] = dat_o;
                  if (e.last) begin
                     chk1("done_low_at_last_ack", done, 1'b0);
                     done_next = 1'b1;
                  end
               end
            end else begin
               if (rd_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_read actual=%h required=none", adr_o);
               end else begin
                  ra = rd_q.pop_front();
                  chk("rd_adr", adr_o, ra);
               end
            end
         end
      end
   end

   function automatic logic [31:0] ref_sum(input int n);
      logic [31:0] s = 32'h0;
`ifdef FLASH_BOOT_CHECKSUM_EN
      for (int i = 0; i < n; i++) s += flash[i];
`endif
      return s;
   endfunction

   task automatic push_copy(input int n_rd, input int n_wr, input bit full);
      for (int i = 0; i < n_rd; i++) rd_q.push_back(SRC + 32'(i) * 32'd4);
      for (int i = 0; i < n_wr; i++)
         exp_q.push_back('{adr: DST + 32'(i) * 32'd4, dat: flash[i], last: full && (i == n_wr - 1)});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int c = 0;
      do begin @(negedge clk); #3; c++; end while (done !== 1'b1 && c < 3000);
      chk1(name, done, 1'b1);
   endtask

   task automatic final_checks();
      logic [31:0] a;
      chk("checksum", checksum, ref_sum(NW));
      chk1("busy_done", busy, 1'b0);
      chk1("cpu_rst_done", cpu_rst, 1'b0);
      chk1("err_done", err, 1'b0);
      chk("wr_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      for (int i = 0; i < NW; i++) begin
         a = DST + 32'(i) * 32'd4;
         chk("ram_word", (ram.exists(a) != 0) ? ram[a] : 32'hBAD0_BAD0, flash[i]);
      end
   endtask

   initial begin
      int c;
      rst = 1'b1;
      start = 1'b0;
      flash[0] = 32'h1122_3344; flash[1] = 32'h5566_7788;
      flash[2] = 32'h99AA_BBCC; flash[3] = 32'hDDEE_FF00;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_adr", adr_o, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_sel", {28'h0, sel_o}, 32'h0);
      chk1("rst_we", we_o, 1'b0);
      chk1("rst_stb", stb_o, 1'b0);
      chk1("rst_cyc", cyc_o, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk("rst_checksum", checksum, 32'h0);
      chk1("rst_cpu_rst", cpu_rst, 1'b1);

      // Auto-started copy of the fixed image; a start pulse mid-copy must be ignored.
      push_copy(NW, NW, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      #3;
      chk1("busy_mid_copy", busy, 1'b1);
      pulse_start();
      wait_done("copy1_done");
      final_checks();

      // Randomized images and latencies, restarted from DONE.
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < NW; i++) flash[i] = $urandom;
         rd_lat = $urandom_range(14, 1);
         wr_lat = $urandom_range(5, 1);
         ram.delete();
         chk1("done_sticky", done, 1'b1);
         push_copy(NW, NW, 1'b1);
         pulse_start();
         #3;
         chk1("restart_busy", busy, 1'b1);
         chk1("restart_cpu_rst", cpu_rst, 1'b1);
         chk1("restart_done_clr", done, 1'b0);
         chk("restart_checksum_clr", checksum, 32'h0);
         wait_done("rand_copy_done");
         final_checks();
      end

      // Flash never acks word 2: timeout after TO cycles, words 0 and 1 written only.
      stall_word = 2;
      stall_cnt = 0;
      ram.delete();
      push_copy(3, 2, 1'b0);
      pulse_start();
      c = 0;
      do begin @(negedge clk); #3; c++; end while (err !== 1'b1 && c < 3000);
      chk1("err_set", err, 1'b1);
      chk1("err_cpu_rst", cpu_rst, 1'b1);
      chk1("err_busy", busy, 1'b0);
      chk1("err_done", done, 1'b0);
      chk1("err_cyc", cyc_o, 1'b0);
      chk("stall_cycles", 32'(stall_cnt), 32'(TO));
      chk("err_writes_drained", 32'(exp_q.size()), 32'd0);
      chk("err_checksum", checksum, ref_sum(2));
      chk1("ram_w0_written", ram.exists(DST) != 0, 1'b1);
      chk1("ram_w1_written", ram.exists(DST + 32'd4) != 0, 1'b1);
      chk1("ram_w2_absent", ram.exists(DST + 32'd8) != 0, 1'b0);
      repeat (5) @(negedge clk);
      #3;
      chk1("err_held", err, 1'b1);
      chk1("err_bus_idle", cyc_o, 1'b0);
      rd_q.delete();
      stall_word = -1;

      // Reset during the second write, then auto-restart from word 0.
      ram.delete();
      push_copy(NW, NW, 1'b1);
      pulse_start();
      c = 0;
      do begin @(negedge clk); #3; c++; end
      while (!(cyc_o === 1'b1 && we_o === 1'b1 && adr_o === DST + 32'd4) && c < 3000);
      chk1("mid_wr_reached", cyc_o && we_o, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk1("arst_cyc", cyc_o, 1'b0);
      chk1("arst_stb", stb_o, 1'b0);
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_cpu_rst", cpu_rst, 1'b1);
      exp_q.delete();
      rd_q.delete();
      ram.delete();
      push_copy(NW, NW, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      wait_done("post_reset_copy_done");
      final_checks();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
